// File: rtl/riscv_mem_pkg.sv
// Shared types and decode helpers for the MEM pipeline stage.
// Opcode names are right-aligned ASCII, zero-padded on the left.
package riscv_mem_pkg;

    localparam int NAME_W = 12 * 8 + 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;

    typedef enum logic [3:0] {
        MEM_NONE, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD
    } mem_kind_t;

    function automatic mem_kind_t decode_mem_kind(input logic [NAME_W-1:0] name);
        mem_kind_t k;
        case (name)
            NAME_W'("lb"):  k = LB;
            NAME_W'("lh"):  k = LH;
            NAME_W'("lw"):  k = LW;
            NAME_W'("ld"):  k = LD;
            NAME_W'("lbu"): k = LBU;
            NAME_W'("lhu"): k = LHU;
            NAME_W'("lwu"): k = LWU;
            NAME_W'("sb"):  k = SB;
            NAME_W'("sh"):  k = SH;
            NAME_W'("sw"):  k = SW;
            NAME_W'("sd"):  k = SD;
            default:        k = MEM_NONE;
        endcase
        return k;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input mem_kind_t k);
        case (k)
            LH, LHU, SH: return 3'b001;
            LW, LWU, SW: return 3'b011;
            LD, SD:      return 3'b111;
            default:     return 3'b000;
        endcase
    endfunction

    function automatic logic is_store(input mem_kind_t k);
        return (k == SB) || (k == SH) || (k == SW) || (k == SD);
    endfunction

endpackage

// File: rtl/load_align_extend.sv
// Purpose: shift a 64-bit memory word down to the access lane, then size and extend it.
// Latency: combinational.
// Backpressure: none.
module load_align_extend
    import riscv_mem_pkg::*;
(
    input  logic [63:0] resp_dat,
    input  logic [2:0]  off,
    input  mem_kind_t   kind,
    output logic [63:0] load_dat
);

    logic [63:0] lane;

    always_comb begin
        lane = resp_dat >> {off, 3'b000};
        case (kind)
            LB:      load_dat = {{56{lane[7]}},  lane[7:0]};
            LH:      load_dat = {{48{lane[15]}}, lane[15:0]};
            LW:      load_dat = {{32{lane[31]}}, lane[31:0]};
            LBU:     load_dat = {56'd0, lane[7:0]};
            LHU:     load_dat = {48'd0, lane[15:0]};
            LWU:     load_dat = {32'd0, lane[31:0]};
            default: load_dat = lane;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Purpose: MEM stage; drives the data-memory port for loads/stores, aligns loads, registers writeback.
// Latency: non-memory op 1 cycle; memory op 1 + request wait + response wait + 1.
// Backpressure: stage3_stall while not IDLE; dmem_req_ready holds REQ; writeback never stalls.
// Option MEM_STAGE_MISALIGN_TRAP_EN: misaligned accesses report instead of forcing alignment.
module memory_access_stage
    import riscv_mem_pkg::*;
#(
    parameter int BUS_DATA_WIDTH         = 64,
    parameter int REGISTER_WIDTH         = 64,
    parameter int REGISTER_NUMBER_WIDTH  = 5,
    parameter int INSTRUCTION_NAME_WIDTH = 12
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                stage3_valid,
    input  logic [REGISTER_WIDTH-1:0]           stage3_alu_result,
    input  logic [REGISTER_WIDTH-1:0]           stage3_rs2_val,
    input  logic [REGISTER_NUMBER_WIDTH:0]      stage3_rd,
    input  logic [INSTRUCTION_NAME_WIDTH*8:0]   stage3_opcode_name,
    input  logic [BUS_DATA_WIDTH-1:0]           stage3_pc,
    output logic                                stage3_stall,
    output logic                                dmem_req_valid,
    input  logic                                dmem_req_ready,
    output logic [BUS_DATA_WIDTH-1:0]           dmem_addr,
    output logic                                dmem_we,
    output logic [BUS_DATA_WIDTH-1:0]           dmem_wdata,
    output logic [7:0]                          dmem_wstrb,
    input  logic                                dmem_resp_valid,
    input  logic [BUS_DATA_WIDTH-1:0]           dmem_resp_data,
    output logic                                nstage4_valid,
    output logic [REGISTER_WIDTH-1:0]           nstage4_result,
    output logic [REGISTER_NUMBER_WIDTH:0]      nstage4_rd,
    output logic [INSTRUCTION_NAME_WIDTH*8:0]   nstage4_opcode_name,
    output logic [BUS_DATA_WIDTH-1:0]           nstage4_pc
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic                                nstage4_misaligned
`endif
);

    mem_state_t                        state_q, state_d;
    mem_kind_t                         kind_q, kind_d;
    logic [BUS_DATA_WIDTH-1:0]         addr_q, addr_d;
    logic [REGISTER_WIDTH-1:0]         wdat_q, wdat_d;
    logic [REGISTER_NUMBER_WIDTH:0]    rd_q, rd_d;
    logic [INSTRUCTION_NAME_WIDTH*8:0] name_q, name_d;
    logic [BUS_DATA_WIDTH-1:0]         pc_q, pc_d;

    logic                              wb_vld_q, wb_vld_d;
    logic [REGISTER_WIDTH-1:0]         wb_result_q, wb_result_d;
    logic [REGISTER_NUMBER_WIDTH:0]    wb_rd_q, wb_rd_d;
    logic [INSTRUCTION_NAME_WIDTH*8:0] wb_name_q, wb_name_d;
    logic [BUS_DATA_WIDTH-1:0]         wb_pc_q, wb_pc_d;

    mem_kind_t   in_kind;
    logic        capture;
    logic        in_trap;
    logic [2:0]  off;
    logic [63:0] load_dat;

    assign in_kind = decode_mem_kind(stage3_opcode_name);
    assign capture = (state_q == IDLE) && stage3_valid;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic wb_mis_q, wb_mis_d;
    assign in_trap = (stage3_alu_result[2:0] & align_mask(in_kind)) != 3'b000;
`else
    assign in_trap = 1'b0;
`endif

    // Misaligned low bits are dropped, so every access lands on its natural lane.
    assign off = addr_q[2:0] & ~align_mask(kind_q);

    load_align_extend u_load_align_extend (
        .resp_dat (dmem_resp_data),
        .off      (off),
        .kind     (kind_q),
        .load_dat (load_dat)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (capture && in_kind != MEM_NONE && !in_trap) state_d = REQ;
            REQ:     if (dmem_req_ready) state_d = WAIT;
            WAIT:    if (dmem_resp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stage3_stall   = (state_q != IDLE);
        dmem_req_valid = 1'b0;
        dmem_addr      = '0;
        dmem_we        = 1'b0;
        dmem_wdata     = '0;
        dmem_wstrb     = 8'h00;
        if (state_q == REQ) begin
            dmem_req_valid = 1'b1;
            dmem_addr      = {addr_q[BUS_DATA_WIDTH-1:3], 3'b000};
            dmem_we        = is_store(kind_q);
            if (is_store(kind_q)) dmem_wdata = wdat_q << {off, 3'b000};
            case (kind_q)
                SB:      dmem_wstrb = 8'h01 << off;
                SH:      dmem_wstrb = 8'h03 << off;
                SW:      dmem_wstrb = 8'h0F << off;
                SD:      dmem_wstrb = 8'hFF;
                default: dmem_wstrb = 8'h00;
            endcase
        end
    end

    always_comb begin
        kind_d = kind_q;
        addr_d = addr_q;
        wdat_d = wdat_q;
        rd_d   = rd_q;
        name_d = name_q;
        pc_d   = pc_q;
        if (capture && in_kind != MEM_NONE && !in_trap) begin
            kind_d = in_kind;
            addr_d = stage3_alu_result;
            wdat_d = stage3_rs2_val;
            rd_d   = stage3_rd;
            name_d = stage3_opcode_name;
            pc_d   = stage3_pc;
        end
    end

    always_comb begin
        wb_vld_d    = 1'b0;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_name_d   = wb_name_q;
        wb_pc_d     = wb_pc_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        wb_mis_d    = 1'b0;
`endif
        if (capture && (in_kind == MEM_NONE || in_trap)) begin
            wb_vld_d    = 1'b1;
            wb_result_d = stage3_alu_result;
            wb_rd_d     = stage3_rd;
            wb_name_d   = stage3_opcode_name;
            wb_pc_d     = stage3_pc;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            wb_mis_d    = in_trap;
`endif
        end else if (state_q == WAIT && dmem_resp_valid) begin
            wb_vld_d    = 1'b1;
            wb_result_d = is_store(kind_q) ? '0 : load_dat;
            wb_rd_d     = rd_q;
            wb_name_d   = name_q;
            wb_pc_d     = pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            kind_q      <= MEM_NONE;
            addr_q      <= '0;
            wdat_q      <= '0;
            rd_q        <= '0;
            name_q      <= '0;
            pc_q        <= '0;
            wb_vld_q    <= 1'b0;
            wb_result_q <= '0;
            wb_rd_q     <= '0;
            wb_name_q   <= '0;
            wb_pc_q     <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            wb_mis_q    <= 1'b0;
`endif
        end else begin
            kind_q      <= kind_d;
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            rd_q        <= rd_d;
            name_q      <= name_d;
            pc_q        <= pc_d;
            wb_vld_q    <= wb_vld_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_name_q   <= wb_name_d;
            wb_pc_q     <= wb_pc_d;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            wb_mis_q    <= wb_mis_d;
`endif
        end
    end

    assign nstage4_valid       = wb_vld_q;
    assign nstage4_result      = wb_result_q;
    assign nstage4_rd          = wb_rd_q;
    assign nstage4_opcode_name = wb_name_q;
    assign nstage4_pc          = wb_pc_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign nstage4_misaligned  = wb_mis_q;
`endif

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: inputs driven and outputs sampled on the falling edge.
module tb_memory_access_stage;

    localparam int NW = 12 * 8 + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stage3_valid;
    logic [63:0]   stage3_alu_result;
    logic [63:0]   stage3_rs2_val;
    logic [5:0]    stage3_rd;
    logic [NW-1:0] stage3_opcode_name;
    logic [63:0]   stage3_pc;
    logic          stage3_stall;
    logic          dmem_req_valid;
    logic          dmem_req_ready;
    logic [63:0]   dmem_addr;
    logic          dmem_we;
    logic [63:0]   dmem_wdata;
    logic [7:0]    dmem_wstrb;
    logic          dmem_resp_valid;
    logic [63:0]   dmem_resp_data;
    logic          nstage4_valid;
    logic [63:0]   nstage4_result;
    logic [5:0]    nstage4_rd;
    logic [NW-1:0] nstage4_opcode_name;
    logic [63:0]   nstage4_pc;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic          nstage4_misaligned;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .stage3_valid        (stage3_valid),
        .stage3_alu_result   (stage3_alu_result),
        .stage3_rs2_val      (stage3_rs2_val),
        .stage3_rd           (stage3_rd),
        .stage3_opcode_name  (stage3_opcode_name),
        .stage3_pc           (stage3_pc),
        .stage3_stall        (stage3_stall),
        .dmem_req_valid      (dmem_req_valid),
        .dmem_req_ready      (dmem_req_ready),
        .dmem_addr           (dmem_addr),
        .dmem_we             (dmem_we),
        .dmem_wdata          (dmem_wdata),
        .dmem_wstrb          (dmem_wstrb),
        .dmem_resp_valid     (dmem_resp_valid),
        .dmem_resp_data      (dmem_resp_data),
        .nstage4_valid       (nstage4_valid),
        .nstage4_result      (nstage4_result),
        .nstage4_rd          (nstage4_rd),
        .nstage4_opcode_name (nstage4_opcode_name),
        .nstage4_pc          (nstage4_pc)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .nstage4_misaligned  (nstage4_misaligned)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic [NW-1:0] nm, input logic [63:0] alu, input logic [63:0] rs2,
                         input logic [5:0] rd, input logic [63:0] pc);
        stage3_valid       = 1'b1;
        stage3_opcode_name = nm;
        stage3_alu_result  = alu;
        stage3_rs2_val     = rs2;
        stage3_rd          = rd;
        stage3_pc          = pc;
    endtask

    initial begin
        reset_n            = 1'b0;
        stage3_valid       = 1'b0;
        stage3_alu_result  = '0;
        stage3_rs2_val     = '0;
        stage3_rd          = '0;
        stage3_opcode_name = '0;
        stage3_pc          = '0;
        dmem_req_ready     = 1'b0;
        dmem_resp_valid    = 1'b0;
        dmem_resp_data     = '0;
        step();

        check("rst_stall",  64'(stage3_stall),   64'd0);
        check("rst_req",    64'(dmem_req_valid), 64'd0);
        check("rst_addr",   dmem_addr,           64'd0);
        check("rst_wstrb",  64'(dmem_wstrb),     64'd0);
        check("rst_nvld",   64'(nstage4_valid),  64'd0);
        check("rst_result", nstage4_result,      64'd0);
        reset_n = 1'b1;
        step();

        // Non-memory op: one-cycle passthrough, never stalls.
        issue(NW'("addi"), 64'h2A, 64'h0, 6'd5, 64'h100);
        check("addi_stall_pre", 64'(stage3_stall), 64'd0);
        step();
        stage3_valid = 1'b0;
        check("addi_vld",    64'(nstage4_valid), 64'd1);
        check("addi_result", nstage4_result,     64'h2A);
        check("addi_rd",     64'(nstage4_rd),    64'd5);
        check("addi_pc",     nstage4_pc,         64'h100);
        check("addi_stall",  64'(stage3_stall),  64'd0);
        step();
        check("addi_pulse",  64'(nstage4_valid), 64'd0);

        // lb from byte lane 3 with the sign bit set.
        issue(NW'("lb"), 64'h1003, 64'h0, 6'd7, 64'h104);
        step();
        stage3_valid = 1'b0;
        check("lb_stall", 64'(stage3_stall),   64'd1);
        check("lb_req",   64'(dmem_req_valid), 64'd1);
        check("lb_addr",  dmem_addr,           64'h1000);
        check("lb_we",    64'(dmem_we),        64'd0);
        check("lb_nvld",  64'(nstage4_valid),  64'd0);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("lb_wait_req",   64'(dmem_req_valid), 64'd0);
        check("lb_wait_stall", 64'(stage3_stall),   64'd1);
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h00000000_80000000;
        // Next op is already presented while the stage is busy; it must be taken as soon as IDLE.
        issue(NW'("lbu"), 64'h1003, 64'h0, 6'd8, 64'h108);
        step();
        dmem_resp_valid = 1'b0;
        check("lb_vld",    64'(nstage4_valid), 64'd1);
        check("lb_result", nstage4_result,     64'hFFFFFFFF_FFFFFF80);
        check("lb_rd",     64'(nstage4_rd),    64'd7);
        check("lb_stall_done", 64'(stage3_stall), 64'd0);
        step();
        stage3_valid = 1'b0;
        check("lbu_b2b_req",  64'(dmem_req_valid), 64'd1);
        check("lbu_b2b_nvld", 64'(nstage4_valid),  64'd0);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        step();
        dmem_resp_valid = 1'b0;
        check("lbu_vld",    64'(nstage4_valid), 64'd1);
        check("lbu_result", nstage4_result,     64'h80);
        check("lbu_rd",     64'(nstage4_rd),    64'd8);

        // sh into lanes 6-7 with ready held low.
        issue(NW'("sh"), 64'h1006, 64'hBEEF, 6'd9, 64'h10C);
        step();
        stage3_valid = 1'b0;
        check("sh_addr",  dmem_addr,           64'h1000);
        check("sh_we",    64'(dmem_we),        64'd1);
        check("sh_wstrb", 64'(dmem_wstrb),     64'hC0);
        check("sh_wdata", dmem_wdata,          64'hBEEF0000_00000000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("sh_hold_req",   64'(dmem_req_valid), 64'd1);
            check("sh_hold_addr",  dmem_addr,           64'h1000);
            check("sh_hold_wdata", dmem_wdata,          64'hBEEF0000_00000000);
            check("sh_hold_stall", 64'(stage3_stall),   64'd1);
            check("sh_hold_nvld",  64'(nstage4_valid),  64'd0);
        end
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h12345678_9ABCDEF0;
        step();
        dmem_resp_valid = 1'b0;
        check("sh_vld",    64'(nstage4_valid), 64'd1);
        check("sh_result", nstage4_result,     64'd0);
        check("sh_rd",     64'(nstage4_rd),    64'd9);

        // Reset while waiting for a response drops the transaction.
        issue(NW'("lw"), 64'h2000, 64'h0, 6'd10, 64'h110);
        step();
        stage3_valid   = 1'b0;
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready = 1'b0;
        check("rstw_pre_stall", 64'(stage3_stall), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rstw_stall", 64'(stage3_stall),   64'd0);
        check("rstw_req",   64'(dmem_req_valid), 64'd0);
        check("rstw_rd",    64'(nstage4_rd),     64'd0);
        check("rstw_pc",    nstage4_pc,          64'd0);
        step();
        reset_n         = 1'b1;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'hFFFFFFFF_FFFFFFFF;
        step();
        dmem_resp_valid = 1'b0;
        check("rstw_nvld",   64'(nstage4_valid),  64'd0);
        check("rstw_result", nstage4_result,      64'd0);
        check("rstw_idle",   64'(stage3_stall),   64'd0);
        step();
        check("rstw_nvld2",  64'(nstage4_valid),  64'd0);

        // Misaligned lw.
        issue(NW'("lw"), 64'h1002, 64'h0, 6'd11, 64'h114);
        step();
        stage3_valid = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        check("mis_vld",    64'(nstage4_valid),      64'd1);
        check("mis_result", nstage4_result,          64'h1002);
        check("mis_flag",   64'(nstage4_misaligned), 64'd1);
        check("mis_req",    64'(dmem_req_valid),     64'd0);
        check("mis_stall",  64'(stage3_stall),       64'd0);
        step();
        check("mis_flag_clr", 64'(nstage4_misaligned), 64'd0);
        check("mis_req2",     64'(dmem_req_valid),     64'd0);
`else
        check("mis_req",   64'(dmem_req_valid), 64'd1);
        check("mis_addr",  dmem_addr,           64'h1000);
        check("mis_stall", 64'(stage3_stall),   64'd1);
        dmem_req_ready = 1'b1;
        step();
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b1;
        dmem_resp_data  = 64'h11223344_89ABCDEF;
        step();
        dmem_resp_valid = 1'b0;
        check("mis_vld",    64'(nstage4_valid), 64'd1);
        check("mis_result", nstage4_result,     64'hFFFFFFFF_89ABCDEF);
        check("mis_rd",     64'(nstage4_rd),    64'd11);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
